i2s_rx_capture: RTL and testbench

//  I2S master receiver for the MEMS microphone. It generates SCK/WS from the 25 MHz board clock,

---
 rtl/i2s_rx_capture.sv | 125 ++++++++++++
 tb/tb_i2s_rx_capture.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/i2s_rx_capture.sv
// I2S master receiver: generates SCK/WS from the system clock, deserialises one
// channel of SD MSB-first and presents each sample on a valid/ready interface.
module i2s_rx_capture #(
  parameter int unsigned CLK_DIV     = 4,
  parameter int unsigned SLOT_BITS   = 32,
  parameter int unsigned SAMPLE_BITS = 16,
  parameter int unsigned CHANNEL     = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  output logic                   i2s_sck,
  output logic                   i2s_ws,
  input  logic                   i2s_sd,
  output logic [SAMPLE_BITS-1:0] sample_out,
  output logic                   sample_valid,
  input  logic                   sample_ready,
  output logic                   overrun
);

  localparam int unsigned FRAME_BITS = 2 * SLOT_BITS;
  localparam int unsigned DIV_W      = $clog2(CLK_DIV);
  localparam int unsigned BIT_W      = $clog2(FRAME_BITS);

  logic [DIV_W-1:0]       div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic                   sck_q, sck_d;
  logic                   ws_q, ws_d;
  logic [SAMPLE_BITS-1:0] shift_q, shift_d;
  logic [SAMPLE_BITS-1:0] sample_q, sample_d;
  logic                   valid_q, valid_d;
  logic                   overrun_q, overrun_d;

  logic                   tick_c, rise_c, fall_c;
  logic                   in_right_c, capture_c, load_c, consume_c;
  logic [BIT_W-1:0]       pos_c, bit_next_c;
  logic [SAMPLE_BITS-1:0] shift_in_c;

  // Event decode: divider terminal count, SCK edge direction, slot position
  always_comb begin
    tick_c     = (div_cnt_q == DIV_W'(CLK_DIV - 1));
    rise_c     = enable & tick_c & ~sck_q;
    fall_c     = enable & tick_c & sck_q;
    in_right_c = (bit_cnt_q >= BIT_W'(SLOT_BITS));
    pos_c      = in_right_c ? (bit_cnt_q - BIT_W'(SLOT_BITS)) : bit_cnt_q;
    bit_next_c = (bit_cnt_q == BIT_W'(FRAME_BITS - 1)) ? '0 : (bit_cnt_q + BIT_W'(1));
    capture_c  = rise_c & (in_right_c == (CHANNEL != 0)) &
                 (pos_c >= BIT_W'(1)) & (pos_c <= BIT_W'(SAMPLE_BITS));
    load_c     = capture_c & (pos_c == BIT_W'(SAMPLE_BITS));
    shift_in_c = {shift_q[SAMPLE_BITS-2:0], i2s_sd};
    consume_c  = valid_q & sample_ready;
  end

  // Next-state: clock generation, shifter, output handshake
  always_comb begin
    div_cnt_d = div_cnt_q;
    bit_cnt_d = bit_cnt_q;
    sck_d     = sck_q;
    ws_d      = ws_q;
    shift_d   = shift_q;
    sample_d  = sample_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;

    if (!enable) begin
      div_cnt_d = '0;
      bit_cnt_d = '0;
      sck_d     = 1'b0;
      ws_d      = 1'b0;
      shift_d   = '0;
    end else begin
      if (tick_c) begin
        div_cnt_d = '0;
        sck_d     = ~sck_q;
      end else begin
        div_cnt_d = div_cnt_q + DIV_W'(1);
      end
      if (fall_c) begin
        bit_cnt_d = bit_next_c;
        ws_d      = (bit_next_c >= BIT_W'(SLOT_BITS));
      end
      if (capture_c) begin
        shift_d = shift_in_c;
      end
    end

    // A new sample wins over consumption; overwrite without a taker is an overrun
    if (load_c) begin
      sample_d  = shift_in_c;
      valid_d   = 1'b1;
      overrun_d = valid_q & ~sample_ready;
    end else if (consume_c) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      sck_q     <= 1'b0;
      ws_q      <= 1'b0;
      shift_q   <= '0;
      sample_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      sck_q     <= sck_d;
      ws_q      <= ws_d;
      shift_q   <= shift_d;
      sample_q  <= sample_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign i2s_sck      = sck_q;
  assign i2s_ws       = ws_q;
  assign sample_out   = sample_q;
  assign sample_valid = valid_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_i2s_rx_capture.sv
// Bench for i2s_rx_capture: a microphone model follows SCK/WS, drives SD words,
// and checks clocking, captured samples, handshake, overrun, enable and reset.
module tb_i2s_rx_capture;

  localparam int unsigned CLK_DIV = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        i2s_sck;
  logic        i2s_ws;
  logic        i2s_sd;
  logic [15:0] sample_out;
  logic        sample_valid;
  logic        sample_ready;
  logic        overrun;

  i2s_rx_capture #(
    .CLK_DIV(4), .SLOT_BITS(32), .SAMPLE_BITS(16), .CHANNEL(0)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .i2s_sck(i2s_sck), .i2s_ws(i2s_ws), .i2s_sd(i2s_sd),
    .sample_out(sample_out), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .overrun(overrun)
  );

  always #20 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Microphone model state
  int          bc;
  int          half_cyc;
  int          wraps;
  int          valid_cyc;
  int          ovr_cyc;
  bit          clk_chk_en;
  logic        prev_sck;
  logic        prev_ws;
  logic [15:0] left_w;
  logic [15:0] right_w;
  logic [15:0] last_sample;

  typedef struct {
    logic [15:0] left;
    logic [15:0] right;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clk cycle: observe DUT just after the edge, then drive SD for the current slot bit
  task automatic step();
    logic        fell;
    logic [15:0] w;
    int          p;
    @(posedge clk);
    #1;
    half_cyc++;
    fell = prev_sck & ~i2s_sck;
    if (clk_chk_en) begin
      if (i2s_sck !== prev_sck) begin
        check("sck_half_period", 32'(half_cyc), CLK_DIV);
        half_cyc = 0;
        if (fell) begin
          bc = (bc + 1) % 64;
          if (bc == 0) wraps++;
          check("ws_level", 32'(i2s_ws), 32'(bc >= 32));
        end
      end
      if (i2s_ws !== prev_ws)
        check("ws_edge_on_sck_fall", 32'({prev_sck, i2s_sck}), 32'b10);
    end
    if (sample_valid === 1'b1) begin
      valid_cyc++;
      last_sample = sample_out;
    end
    if (overrun === 1'b1) ovr_cyc++;
    prev_sck = i2s_sck;
    prev_ws  = i2s_ws;
    p = bc % 32;
    w = (bc >= 32) ? right_w : left_w;
    i2s_sd = (p >= 1 && p <= 16) ? w[16-p] : 1'b1;
  endtask

  task automatic run_frame();
    int start;
    start = wraps;
    for (int i = 0; i < 600 && wraps == start; i++) step();
    check("frame_complete", 32'(wraps != start), 32'd1);
  endtask

  task automatic enable_on();
    enable     = 1'b1;
    bc         = 0;
    half_cyc   = 0;
    prev_sck   = 1'b0;
    prev_ws    = 1'b0;
    clk_chk_en = 1'b1;
    i2s_sd     = 1'b1;
  endtask

  initial begin
    vecs[0] = '{left: 16'hA5C3, right: 16'hFFFF, exp: 16'hA5C3};
    vecs[1] = '{left: 16'h8000, right: 16'hFFFF, exp: 16'h8000};
    vecs[2] = '{left: 16'h7FFF, right: 16'h0000, exp: 16'h7FFF};
    vecs[3] = '{left: 16'h0000, right: 16'hFFFF, exp: 16'h0000};
    vecs[4] = '{left: 16'hFFFF, right: 16'h0000, exp: 16'hFFFF};
    vecs[5] = '{left: 16'h1E0F, right: 16'hC3C3, exp: 16'h1E0F};

    rst = 1'b1; enable = 1'b0; sample_ready = 1'b1; i2s_sd = 1'b0;
    left_w = '0; right_w = '0; last_sample = '0;
    bc = 0; half_cyc = 0; wraps = 0; valid_cyc = 0; ovr_cyc = 0;
    clk_chk_en = 1'b0; prev_sck = 1'b0; prev_ws = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_sck", 32'(i2s_sck), 0);
    check("rst_ws", 32'(i2s_ws), 0);
    check("rst_valid", 32'(sample_valid), 0);
    check("rst_sample", 32'(sample_out), 0);
    check("rst_overrun", 32'(overrun), 0);
    rst = 1'b0;
    repeat (3) step();
    check("idle_sck_low", 32'(i2s_sck), 0);

    // Capture table: one full frame per vector, sink always ready
    enable_on();
    foreach (vecs[i]) begin
      left_w = vecs[i].left; right_w = vecs[i].right;
      valid_cyc = 0; ovr_cyc = 0;
      run_frame();
      check($sformatf("vec%0d_valid_cycles", i), 32'(valid_cyc), 1);
      check($sformatf("vec%0d_sample", i), 32'(last_sample), 32'(vecs[i].exp));
      check($sformatf("vec%0d_no_overrun", i), 32'(ovr_cyc), 0);
    end

    // Backpressure: second sample overwrites the first with a single overrun pulse
    sample_ready = 1'b0;
    left_w = 16'h1234; right_w = 16'hFFFF; ovr_cyc = 0;
    run_frame();
    check("bp_first_valid", 32'(sample_valid), 1);
    check("bp_first_sample", 32'(sample_out), 32'h1234);
    check("bp_first_no_overrun", 32'(ovr_cyc), 0);
    left_w = 16'h5678; ovr_cyc = 0;
    run_frame();
    check("bp_overrun_pulses", 32'(ovr_cyc), 1);
    check("bp_second_sample", 32'(sample_out), 32'h5678);
    check("bp_second_valid", 32'(sample_valid), 1);
    sample_ready = 1'b1;
    step();
    check("bp_consumed", 32'(sample_valid), 0);

    // Disable after 8 data bits of a left slot, then restart with a fresh frame
    left_w = 16'hFFFF;
    for (int i = 0; i < 600 && !(bc == 8 && i2s_sck === 1'b1); i++) step();
    check("dis_reached_bit8", 32'(bc == 8 && i2s_sck === 1'b1), 1);
    enable = 1'b0; clk_chk_en = 1'b0;
    step();
    check("dis_sck_low", 32'(i2s_sck), 0);
    check("dis_ws_low", 32'(i2s_ws), 0);
    valid_cyc = 0;
    repeat (20) step();
    check("dis_no_valid", 32'(valid_cyc), 0);
    check("dis_sck_held", 32'(i2s_sck), 0);
    enable_on();
    left_w = 16'h00FF; right_w = 16'hFFFF; valid_cyc = 0;
    run_frame();
    check("reen_valid_cycles", 32'(valid_cyc), 1);
    check("reen_sample", 32'(last_sample), 32'h00FF);

    // Reset mid-frame with a pending sample
    sample_ready = 1'b0;
    left_w = 16'hABCD;
    run_frame();
    check("pre_rst_valid", 32'(sample_valid), 1);
    repeat (100) step();
    rst = 1'b1;
    #1;
    check("midrst_sck", 32'(i2s_sck), 0);
    check("midrst_ws", 32'(i2s_ws), 0);
    check("midrst_valid", 32'(sample_valid), 0);
    check("midrst_sample", 32'(sample_out), 0);
    check("midrst_overrun", 32'(overrun), 0);
    clk_chk_en = 1'b0;
    repeat (2) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
